// File: rtl/fma_pkg.sv
// Shared FMA types and constants: multiplier lane widths, latency default and the
// tag carried alongside each product through the shared multiplier.
package fma_pkg;

  localparam int unsigned MUL_AW      = 27;
  localparam int unsigned MUL_BW      = 27;
  localparam int unsigned MUL_LAT_DEF = 1;

  // Tags are sized for the largest supported requester count so one type fits every build.
  localparam int unsigned MUL_NREQ_MAX = 8;
  localparam int unsigned MUL_IDW_MAX  = 3;

  typedef struct packed {
    logic                   valid;
    logic [MUL_IDW_MAX-1:0] id;
  } mul_tag_t;

  typedef struct packed {
    logic              en;
    logic [MUL_AW-1:0] a;
    logic [MUL_BW-1:0] b;
  } mulit_t;

  typedef struct packed {
    logic [MUL_AW+MUL_BW-1:0] out;
  } mulot_t;

  // Requester tag width; a single-bit tag is kept even where one requester would need none.
  function automatic int unsigned idw_of(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/mul_share_tag_pipe.sv
// LAT-deep shift register of requester tags that tracks products through the shared
// multiplier; exposes the head tag and a registered busy flag.
module mul_share_tag_pipe
  import fma_pkg::*;
#(
  parameter int unsigned LAT = MUL_LAT_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  mul_tag_t tag_in,
  output mul_tag_t tag_head,
  output logic     busy
);

  mul_tag_t stage      [LAT];
  mul_tag_t stage_next [LAT];
  logic     busy_next;

  always_comb begin
    stage_next[0] = tag_in;
    for (int unsigned i = 1; i < LAT; i++) begin
      stage_next[i] = stage[i-1];
    end
    // busy reflects the stage contents that will be present after this edge.
    busy_next = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      busy_next = busy_next | stage_next[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        stage[i] <= '0;
      end
      busy <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < LAT; i++) begin
        stage[i] <= stage_next[i];
      end
      busy <= busy_next;
    end
  end

  assign tag_head = stage[LAT-1];

endmodule

// File: rtl/mul_share_arb.sv
// Arbiter sharing one pipelined multiplier lane among NREQ requesters, with result steering.
// Define MUL_SHARE_ARB_RR_EN for round-robin arbitration; default is lowest-index-wins.
module mul_share_arb
  import fma_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = MUL_AW,
  parameter int unsigned BW   = MUL_BW,
  parameter int unsigned LAT  = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_a,
  input  logic [NREQ*BW-1:0]   req_b,
  output logic [NREQ-1:0]      req_grant,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [AW+BW-1:0]     rsp_out,
  output logic                 busy,
  output logic                 mul_en,
  output logic [AW-1:0]        mul_a,
  output logic [BW-1:0]        mul_b,
  input  logic [AW+BW-1:0]     mul_out
);

  localparam int unsigned IDW = idw_of(NREQ);

  logic           grant_any;
  logic [IDW-1:0] grant_idx;

`ifdef MUL_SHARE_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_next;
  int unsigned    cand;
  logic           hit;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    hit       = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      hit = 1'b0;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (cand == j) begin
          hit = req_valid[j];
        end
      end
      if (!grant_any && hit) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
    if (!reset) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (grant_any) begin
      rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_next;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(k);
      end
    end
    if (!reset) begin
      grant_any = 1'b0;
    end
  end
`endif

  // Decode the winner and steer its operands onto the lane; zeros when idle.
  always_comb begin
    req_grant = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (grant_any && (grant_idx == IDW'(j))) begin
        req_grant[j] = 1'b1;
        mul_a        = req_a[j*AW +: AW];
        mul_b        = req_b[j*BW +: BW];
      end
    end
  end

  assign mul_en = grant_any;

  mul_tag_t tag_in;
  mul_tag_t tag_head;

  always_comb begin
    tag_in              = '0;
    tag_in.valid        = grant_any;
    tag_in.id[IDW-1:0]  = grant_idx;
  end

  mul_share_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (tag_in),
    .tag_head (tag_head),
    .busy     (busy)
  );

  // Results emerging while reset is low belong to discarded tags and are suppressed.
  always_comb begin
    rsp_valid = '0;
    rsp_out   = '0;
    if (reset && tag_head.valid) begin
      rsp_out = mul_out;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (tag_head.id == MUL_IDW_MAX'(j)) begin
          rsp_valid[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: four instances cover fixed priority, deep latency,
// arbitration under full load, and reset mid-flight, each with a behavioural multiplier lane.
module tb_mul_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Instance A: NREQ=2, LAT=1
  logic [1:0]  a_req_valid, a_grant, a_rsp_valid;
  logic [53:0] a_req_a, a_req_b, a_rsp_out, a_mul_out;
  logic        a_busy, a_mul_en;
  logic [26:0] a_mul_a, a_mul_b;

  mul_share_arb #(.NREQ(2), .LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_a(a_req_a), .req_b(a_req_b),
    .req_grant(a_grant), .rsp_valid(a_rsp_valid), .rsp_out(a_rsp_out), .busy(a_busy),
    .mul_en(a_mul_en), .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_out(a_mul_out)
  );

  always @(posedge clk) a_mul_out <= a_mul_en ? {27'd0, a_mul_a} * {27'd0, a_mul_b} : '0;

  // Instance B: NREQ=4, LAT=3
  logic [3:0]   b_req_valid, b_grant, b_rsp_valid;
  logic [107:0] b_req_a, b_req_b;
  logic [53:0]  b_rsp_out, b_mul_out;
  logic         b_busy, b_mul_en;
  logic [26:0]  b_mul_a, b_mul_b;
  logic [53:0]  b_lane [3];

  mul_share_arb #(.NREQ(4), .LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_a(b_req_a), .req_b(b_req_b),
    .req_grant(b_grant), .rsp_valid(b_rsp_valid), .rsp_out(b_rsp_out), .busy(b_busy),
    .mul_en(b_mul_en), .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_out(b_mul_out)
  );

  always @(posedge clk) begin
    b_lane[0] <= b_mul_en ? {27'd0, b_mul_a} * {27'd0, b_mul_b} : '0;
    b_lane[1] <= b_lane[0];
    b_lane[2] <= b_lane[1];
  end
  assign b_mul_out = b_lane[2];

  // Instance C: NREQ=3, LAT=1
  logic [2:0]  c_req_valid, c_grant, c_rsp_valid;
  logic [80:0] c_req_a, c_req_b;
  logic [53:0] c_rsp_out, c_mul_out;
  logic        c_busy, c_mul_en;
  logic [26:0] c_mul_a, c_mul_b;

  mul_share_arb #(.NREQ(3), .LAT(1)) dut_c (
    .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_a(c_req_a), .req_b(c_req_b),
    .req_grant(c_grant), .rsp_valid(c_rsp_valid), .rsp_out(c_rsp_out), .busy(c_busy),
    .mul_en(c_mul_en), .mul_a(c_mul_a), .mul_b(c_mul_b), .mul_out(c_mul_out)
  );

  always @(posedge clk) c_mul_out <= c_mul_en ? {27'd0, c_mul_a} * {27'd0, c_mul_b} : '0;

  // Instance D: NREQ=2, LAT=2
  logic [1:0]  d_req_valid, d_grant, d_rsp_valid;
  logic [53:0] d_req_a, d_req_b, d_rsp_out, d_mul_out;
  logic        d_busy, d_mul_en;
  logic [26:0] d_mul_a, d_mul_b;
  logic [53:0] d_lane [2];

  mul_share_arb #(.NREQ(2), .LAT(2)) dut_d (
    .clk(clk), .reset(reset), .req_valid(d_req_valid), .req_a(d_req_a), .req_b(d_req_b),
    .req_grant(d_grant), .rsp_valid(d_rsp_valid), .rsp_out(d_rsp_out), .busy(d_busy),
    .mul_en(d_mul_en), .mul_a(d_mul_a), .mul_b(d_mul_b), .mul_out(d_mul_out)
  );

  always @(posedge clk) begin
    d_lane[0] <= d_mul_en ? {27'd0, d_mul_a} * {27'd0, d_mul_b} : '0;
    d_lane[1] <= d_lane[0];
  end
  assign d_mul_out = d_lane[1];

  // Expected tables for the deep-latency and full-load sequences
  logic [3:0]  b_g_exp   [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0};
  logic [3:0]  b_v_exp   [8] = '{4'b0, 4'b0, 4'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0};
  logic [53:0] b_o_exp   [8] = '{54'd0, 54'd0, 54'd0, 54'd1, 54'd4, 54'd9, 54'd16, 54'd0};
  logic        b_busy_exp[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef MUL_SHARE_ARB_RR_EN
  logic [2:0]  c_g_exp [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  logic [2:0]  c_v_exp [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [53:0] c_o_exp [5] = '{54'd0, 54'd20, 54'd30, 54'd40, 54'd20};
`else
  logic [2:0]  c_g_exp [5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
  logic [2:0]  c_v_exp [5] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [53:0] c_o_exp [5] = '{54'd0, 54'd20, 54'd20, 54'd20, 54'd20};
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    a_req_valid = 2'b11;
    a_req_a     = {27'd7, 27'd3};
    a_req_b     = {27'd11, 27'd5};
    b_req_valid = '0; b_req_a = '0; b_req_b = '0;
    c_req_valid = '0; c_req_a = '0; c_req_b = '0;
    d_req_valid = '0; d_req_a = '0; d_req_b = '0;

    // Reset state, with requests pending to prove grants are held off
    cyc(); #1;
    check("rst_grant", a_grant, 2'b00);
    check("rst_mul_en", a_mul_en, 1'b0);
    check("rst_mul_a", a_mul_a, 27'd0);
    cyc(); #1;
    check("rst_busy_all", {a_busy, b_busy, c_busy, d_busy}, 4'b0000);
    check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid, c_rsp_valid, d_rsp_valid}, 11'd0);

    // A: fixed priority, first grant in the release cycle
    cyc(); reset = 1'b1; #1;
    check("a0_grant", a_grant, 2'b01);
    check("a0_mul_a", a_mul_a, 27'd3);
    check("a0_mul_b", a_mul_b, 27'd5);
    check("a0_rsp_valid", a_rsp_valid, 2'b00);
    cyc(); #1;
    check("a1_grant_req0_still_wins", a_grant, 2'b01);
    check("a1_rsp_valid", a_rsp_valid, 2'b01);
    check("a1_rsp_out", a_rsp_out, 54'd15);
    check("a1_busy", a_busy, 1'b1);
    cyc(); a_req_valid = 2'b10; #1;
    check("a2_grant", a_grant, 2'b10);
    check("a2_mul_a", a_mul_a, 27'd7);
    check("a2_mul_b", a_mul_b, 27'd11);
    check("a2_rsp_out", a_rsp_out, 54'd15);
    cyc(); a_req_valid = 2'b00; #1;
    check("a3_grant", a_grant, 2'b00);
    check("a3_mul_en", a_mul_en, 1'b0);
    check("a3_mul_a_zero", a_mul_a, 27'd0);
    check("a3_rsp_valid", a_rsp_valid, 2'b10);
    check("a3_rsp_out", a_rsp_out, 54'd77);
    cyc(); #1;
    check("a4_rsp_valid", a_rsp_valid, 2'b00);
    check("a4_rsp_out", a_rsp_out, 54'd0);
    check("a4_busy", a_busy, 1'b0);

    // A: idle cycle between requests is a bubble
    cyc(); a_req_valid = 2'b01; a_req_a = {27'd4, 27'd2}; a_req_b = {27'd5, 27'd3}; #1;
    check("idle0_grant", a_grant, 2'b01);
    cyc(); a_req_valid = 2'b00; #1;
    check("idle1_mul_en", a_mul_en, 1'b0);
    check("idle1_rsp_valid", a_rsp_valid, 2'b01);
    check("idle1_rsp_out", a_rsp_out, 54'd6);
    cyc(); a_req_valid = 2'b10; #1;
    check("idle2_grant", a_grant, 2'b10);
    check("idle2_bubble_rsp", a_rsp_valid, 2'b00);
    cyc(); a_req_valid = 2'b00; #1;
    check("idle3_rsp_valid", a_rsp_valid, 2'b10);
    check("idle3_rsp_out", a_rsp_out, 54'd20);

    // A: maximum operands, full 54-bit product
    cyc(); a_req_valid = 2'b01; a_req_a = {27'd0, 27'h7FFFFFF}; a_req_b = {27'd0, 27'h7FFFFFF}; #1;
    check("max_mul_a", a_mul_a, 27'h7FFFFFF);
    cyc(); a_req_valid = 2'b00; #1;
    check("max_rsp_valid", a_rsp_valid, 2'b01);
    check("max_rsp_out", a_rsp_out, 54'h3FFFFFF0000001);

    // B: requester 2 back-to-back through a 3-cycle lane
    for (int k = 0; k < 8; k++) begin
      cyc();
      b_req_valid = (k < 4) ? 4'b0100 : 4'b0000;
      b_req_a     = {27'd0, 27'(k + 1), 54'd0};
      b_req_b     = {27'd0, 27'(k + 1), 54'd0};
      #1;
      check($sformatf("b_grant[%0d]", k), b_grant, b_g_exp[k]);
      check($sformatf("b_rsp_valid[%0d]", k), b_rsp_valid, b_v_exp[k]);
      check($sformatf("b_rsp_out[%0d]", k), b_rsp_out, b_o_exp[k]);
      check($sformatf("b_busy[%0d]", k), b_busy, b_busy_exp[k]);
    end

    // C: all three requesters valid for 4 cycles
    c_req_a = {27'd4, 27'd3, 27'd2};
    c_req_b = {27'd10, 27'd10, 27'd10};
    for (int k = 0; k < 5; k++) begin
      cyc();
      c_req_valid = (k < 4) ? 3'b111 : 3'b000;
      #1;
      check($sformatf("c_grant[%0d]", k), c_grant, c_g_exp[k]);
      check($sformatf("c_rsp_valid[%0d]", k), c_rsp_valid, c_v_exp[k]);
      check($sformatf("c_rsp_out[%0d]", k), c_rsp_out, c_o_exp[k]);
    end

    // D: reset with two products in flight, then a fresh grant
    cyc(); d_req_valid = 2'b10; d_req_a = {27'd5, 27'd0}; d_req_b = {27'd6, 27'd0}; #1;
    check("d0_grant", d_grant, 2'b10);
    cyc(); #1;
    check("d1_grant", d_grant, 2'b10);
    check("d1_busy", d_busy, 1'b1);
    check("d1_rsp_valid", d_rsp_valid, 2'b00);
    cyc(); reset = 1'b0; #1;
    check("d2_grant_in_reset", d_grant, 2'b00);
    check("d2_mul_en_in_reset", d_mul_en, 1'b0);
    check("d2_rsp_valid_in_reset", d_rsp_valid, 2'b00);
    cyc(); reset = 1'b1; d_req_a = {27'd9, 27'd0}; d_req_b = {27'd9, 27'd0}; #1;
    check("d3_busy_after_reset", d_busy, 1'b0);
    check("d3_rsp_valid", d_rsp_valid, 2'b00);
    check("d3_grant_on_release", d_grant, 2'b10);
    cyc(); d_req_valid = 2'b00; #1;
    check("d4_rsp_valid", d_rsp_valid, 2'b00);
    check("d4_busy", d_busy, 1'b1);
    cyc(); #1;
    check("d5_rsp_valid", d_rsp_valid, 2'b10);
    check("d5_rsp_out", d_rsp_out, 54'd81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
